smart_parking_gen2: RTL and testbench

//  Parametrised second-generation parking gate controller. Runs the entry/password
//  FSM and tracks lot occupancy against CAPACITY. Limits wrong-password retries

---
 rtl/smart_parking_gen2.sv | 174 +++++++++++++++++
 tb/tb_smart_parking_gen2.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smart_parking_gen2.sv
// Parking gate controller: entry/password FSM, occupancy count, retry lockout and entry timeout.
// Optional macro LED_BLINK_EN makes RED_LED blink in WRONG_PASS and STOP.
module smart_parking_gen2 #(
  parameter int                  PW_WIDTH    = 4,
  parameter logic [PW_WIDTH-1:0] PASSWORD    = 4'b1101,
  parameter int                  CAPACITY    = 8,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  TIMEOUT_CYC = 16,
  parameter int                  LOCKOUT_CYC = 32,
  parameter int                  BLINK_DIV   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sensor_entry,
  input  logic                          sensor_exit,
  input  logic [PW_WIDTH-1:0]           password,
  input  logic                          pw_valid,
  output logic                          GREEN_LED,
  output logic                          RED_LED,
  output logic                          BLUE_LED,
  output logic                          YELLOW_LED,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic                          lot_full
);

  localparam int OCC_W = $clog2(CAPACITY + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int T_MAX = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
  localparam int TMR_W = $clog2(T_MAX + 1);

  localparam logic [OCC_W-1:0] OCC_FULL     = OCC_W'(CAPACITY);
  localparam logic [TRY_W-1:0] TRIES_LIMIT  = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LAST = TMR_W'(LOCKOUT_CYC - 1);

  if (PW_WIDTH < 1 || CAPACITY < 1 || MAX_TRIES < 1 || TIMEOUT_CYC < 1 ||
      LOCKOUT_CYC < 1 || BLINK_DIV < 0) begin : g_bad_params
    $error("smart_parking_gen2: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PASS,
    S_WRONG_PASS,
    S_RIGHT_PASS,
    S_STOP,
    S_LOCKOUT
  } state_t;

  state_t             state_reg, state_next;
  logic [OCC_W-1:0]   occ_reg, occ_next, occ_inc;
  logic [TRY_W-1:0]   tries_reg, tries_next, tries_inc;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic               entry_prev_reg, exit_prev_reg;
  logic               entry_rise, exit_rise;
  logic               pw_ok, pw_bad;
  logic               timer_restart;
  logic               red_flash;

  assign entry_rise = sensor_entry & ~entry_prev_reg;
  assign exit_rise  = sensor_exit & ~exit_prev_reg;
  assign pw_ok      = pw_valid & (password == PASSWORD);
  assign pw_bad     = pw_valid & (password != PASSWORD);
  assign occ_inc    = (occ_reg == OCC_FULL) ? occ_reg : occ_reg + 1'b1;
  assign tries_inc  = tries_reg + 1'b1;

  assign lot_full  = (occ_reg == OCC_FULL);
  assign occupancy = occ_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      occ_reg        <= '0;
      tries_reg      <= '0;
      timer_reg      <= '0;
      entry_prev_reg <= 1'b0;
      exit_prev_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      occ_reg        <= occ_next;
      tries_reg      <= tries_next;
      timer_reg      <= timer_next;
      entry_prev_reg <= sensor_entry;
      exit_prev_reg  <= sensor_exit;
    end
  end

  always_comb begin
    state_next    = state_reg;
    occ_next      = occ_reg;
    tries_next    = tries_reg;
    timer_restart = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // A simultaneous entry is dropped so the departing car is always counted
        if (exit_rise) begin
          if (occ_reg != '0) occ_next = occ_reg - 1'b1;
        end else if (entry_rise && !lot_full) begin
          state_next = S_WAIT_PASS;
        end
      end
      S_WAIT_PASS, S_WRONG_PASS: begin
        if (pw_ok) begin
          tries_next = '0;
          state_next = S_RIGHT_PASS;
        end else if (pw_bad) begin
          tries_next    = tries_inc;
          timer_restart = 1'b1;
          state_next    = (tries_inc == TRIES_LIMIT) ? S_LOCKOUT : S_WRONG_PASS;
        end else if (timer_reg == TIMEOUT_LAST) begin
          tries_next = '0;
          state_next = S_IDLE;
        end
      end
      S_RIGHT_PASS: begin
        if (exit_rise) begin
          occ_next   = occ_inc;
          state_next = entry_rise ? S_STOP : S_IDLE;
        end
      end
      S_STOP: begin
        if (pw_ok) state_next = S_RIGHT_PASS;
      end
      S_LOCKOUT: begin
        if (timer_reg == LOCKOUT_LAST) begin
          tries_next = '0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Timer saturates so long stays in untimed states never wrap
    if (state_next != state_reg || timer_restart)
      timer_next = '0;
    else if (timer_reg == '1)
      timer_next = timer_reg;
    else
      timer_next = timer_reg + 1'b1;
  end

`ifdef LED_BLINK_EN
  logic [BLINK_DIV:0] blink_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) blink_cnt_reg <= '0;
    else      blink_cnt_reg <= blink_cnt_reg + 1'b1;
  end

  assign red_flash = blink_cnt_reg[BLINK_DIV];
`else
  assign red_flash = 1'b1;
`endif

  always_comb begin
    GREEN_LED  = 1'b0;
    RED_LED    = 1'b0;
    BLUE_LED   = 1'b0;
    YELLOW_LED = 1'b0;
    case (state_reg)
      S_IDLE:       RED_LED = lot_full;
      S_WAIT_PASS:  YELLOW_LED = 1'b1;
      S_WRONG_PASS: RED_LED = red_flash;
      S_RIGHT_PASS: GREEN_LED = 1'b1;
      S_STOP: begin
        RED_LED    = red_flash;
        YELLOW_LED = 1'b1;
      end
      S_LOCKOUT:    BLUE_LED = 1'b1;
      default:      ;
    endcase
  end

endmodule

// File: tb/tb_smart_parking_gen2.sv
// Bench for smart_parking_gen2: cycle-stamped behavioural model checked every cycle,
// plus directed scenarios with literal expectations. Honours LED_BLINK_EN if defined.
module tb_smart_parking_gen2;

  localparam int         PW_WIDTH    = 4;
  localparam logic [3:0] PASSWORD    = 4'b1101;
  localparam int         CAPACITY    = 8;
  localparam int         MAX_TRIES   = 3;
  localparam int         TIMEOUT_CYC = 16;
  localparam int         LOCKOUT_CYC = 32;
  localparam int         BLINK_DIV   = 2;
  localparam logic [3:0] PW_BAD      = 4'b0001;
`ifdef LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  // Model phases
  localparam int P_IDLE = 0, P_WAIT = 1, P_WRONG = 2, P_GREEN = 3, P_STOP = 4, P_LOCK = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sensor_entry = 1'b0;
  logic       sensor_exit = 1'b0;
  logic [3:0] password = 4'b0000;
  logic       pw_valid = 1'b0;
  logic       GREEN_LED, RED_LED, BLUE_LED, YELLOW_LED;
  logic [3:0] occupancy;
  logic       lot_full;
  logic [3:0] leds;

  int passed = 0;
  int total  = 0;

  int m_phase = P_IDLE;
  int m_cars  = 0;
  int m_wrong = 0;
  int m_since = 0;
  int m_edges = 0;
  bit m_pe = 1'b0;
  bit m_px = 1'b0;

  smart_parking_gen2 #(
    .PW_WIDTH(PW_WIDTH), .PASSWORD(PASSWORD), .CAPACITY(CAPACITY),
    .MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TIMEOUT_CYC),
    .LOCKOUT_CYC(LOCKOUT_CYC), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .sensor_entry(sensor_entry), .sensor_exit(sensor_exit),
    .password(password), .pw_valid(pw_valid),
    .GREEN_LED(GREEN_LED), .RED_LED(RED_LED), .BLUE_LED(BLUE_LED), .YELLOW_LED(YELLOW_LED),
    .occupancy(occupancy), .lot_full(lot_full)
  );

  assign leds = {GREEN_LED, RED_LED, BLUE_LED, YELLOW_LED};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Red is don't-care in blinking states when the blink build is in use
  task automatic chk_leds(input string name, input logic [3:0] exp, input bit red_blinks);
    logic [3:0] m;
    m = (BLINK && red_blinks) ? 4'b1011 : 4'b1111;
    chk(name, leds & m, exp & m);
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_since = m_edges + 1;
  endtask

  function automatic logic [3:0] model_leds();
    logic flash;
    flash = BLINK ? 1'((m_edges >> BLINK_DIV) & 1) : 1'b1;
    case (m_phase)
      P_IDLE:  return {1'b0, m_cars == CAPACITY, 2'b00};
      P_WAIT:  return 4'b0001;
      P_WRONG: return {1'b0, flash, 2'b00};
      P_GREEN: return 4'b1000;
      P_STOP:  return {1'b0, flash, 1'b0, 1'b1};
      default: return 4'b0010;
    endcase
  endfunction

  // Behavioural model: phases with entry timestamps; ages derived from the edge count
  initial begin
    bit ent, ext, ok, bad;
    int age;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_phase = P_IDLE; m_cars = 0; m_wrong = 0; m_since = 0; m_edges = 0;
        m_pe = 1'b0; m_px = 1'b0;
      end else begin
        ent = sensor_entry && !m_pe;
        ext = sensor_exit && !m_px;
        m_pe = sensor_entry;
        m_px = sensor_exit;
        ok  = pw_valid && (password == PASSWORD);
        bad = pw_valid && (password != PASSWORD);
        age = m_edges - m_since;
        case (m_phase)
          P_IDLE: begin
            if (ext) begin
              if (m_cars > 0) m_cars--;
            end else if (ent && m_cars < CAPACITY) enter(P_WAIT);
          end
          P_WAIT, P_WRONG: begin
            if (ok) begin
              m_wrong = 0; enter(P_GREEN);
            end else if (bad) begin
              m_wrong++;
              enter(m_wrong >= MAX_TRIES ? P_LOCK : P_WRONG);
            end else if (age >= TIMEOUT_CYC - 1) begin
              m_wrong = 0; enter(P_IDLE);
            end
          end
          P_GREEN: begin
            if (ext) begin
              if (m_cars < CAPACITY) m_cars++;
              enter(ent ? P_STOP : P_IDLE);
            end
          end
          P_STOP: if (ok) enter(P_GREEN);
          default: begin
            if (age >= LOCKOUT_CYC - 1) begin
              m_wrong = 0; enter(P_IDLE);
            end
          end
        endcase
        m_edges++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("cyc_leds", leds, model_leds());
    chk("cyc_occ", occupancy, m_cars);
    chk("cyc_full", lot_full, m_cars == CAPACITY);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pw(input logic [3:0] code);
    password = code;
    pw_valid = 1'b1;
    tick();
    pw_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("reset_leds", leds, 4'b0000);
    chk("reset_occ", occupancy, 0);
    chk("reset_full", lot_full, 1'b0);
    rst = 1'b1;
    tick();

    // Exit at zero occupancy is ignored
    sensor_exit = 1'b1; tick();
    chk("underflow_occ", occupancy, 0);
    chk_leds("underflow_leds", 4'b0000, 1'b0);
    sensor_exit = 1'b0; tick();

    // Normal entry
    sensor_entry = 1'b1; tick();
    chk_leds("t1_yellow", 4'b0001, 1'b0);
    sensor_entry = 1'b0;
    pw(PASSWORD);
    chk_leds("t1_green", 4'b1000, 1'b0);
    sensor_exit = 1'b1; tick();
    chk_leds("t1_idle", 4'b0000, 1'b0);
    chk("t1_occ", occupancy, 1);
    sensor_exit = 1'b0; tick();

    // Three wrong codes -> lockout, inputs ignored meanwhile
    sensor_entry = 1'b1; tick(); sensor_entry = 1'b0;
    pw(PW_BAD);
    chk_leds("t3_red", 4'b0100, 1'b1);
    pw(PW_BAD);
    pw(PW_BAD);
    chk_leds("t3_blue", 4'b0010, 1'b0);
    sensor_entry = 1'b1; tick(); sensor_entry = 1'b0; tick();
    pw(PASSWORD);
    repeat (28) tick();
    chk_leds("t3_still_locked", 4'b0010, 1'b0);
    tick();
    chk_leds("t3_unlocked", 4'b0000, 1'b0);
    chk("t3_occ", occupancy, 1);

    // Abandoned entry times out after 16 cycles
    sensor_entry = 1'b1; tick(); sensor_entry = 1'b0;
    repeat (15) tick();
    chk_leds("t4_still_wait", 4'b0001, 1'b0);
    tick();
    chk_leds("t4_timeout", 4'b0000, 1'b0);
    sensor_entry = 1'b1; tick(); sensor_entry = 1'b0;
    pw(PW_BAD);
    pw(PASSWORD);
    chk_leds("t4_green", 4'b1000, 1'b0);
    sensor_exit = 1'b1; tick(); sensor_exit = 1'b0; tick();
    chk("t4_occ", occupancy, 2);

    // Tailgater: both sensors rise in RIGHT_PASS
    sensor_entry = 1'b1; tick(); sensor_entry = 1'b0;
    pw(PASSWORD);
    sensor_entry = 1'b1; sensor_exit = 1'b1; tick();
    chk_leds("t6_stop", 4'b0101, 1'b1);
    chk("t6_occ", occupancy, 3);
    sensor_entry = 1'b0; sensor_exit = 1'b0;
    pw(4'b0000);
    chk_leds("t6_stop_hold", 4'b0101, 1'b1);
    pw(PASSWORD);
    chk_leds("t6_green", 4'b1000, 1'b0);
    sensor_exit = 1'b1; tick(); sensor_exit = 1'b0; tick();
    chk("t6_occ_after", occupancy, 4);

    // Fill the lot
    for (int i = 0; i < 4; i++) begin
      sensor_entry = 1'b1; tick(); sensor_entry = 1'b0;
      pw(PASSWORD);
      sensor_exit = 1'b1; tick(); sensor_exit = 1'b0; tick();
    end
    chk("t5_occ_full", occupancy, 8);
    chk("t5_full", lot_full, 1'b1);
    chk_leds("t5_red_full", 4'b0100, 1'b0);
    sensor_entry = 1'b1; tick(); sensor_entry = 1'b0; tick();
    chk_leds("t5_rejected", 4'b0100, 1'b0);
    chk("t5_occ_rejected", occupancy, 8);
    sensor_exit = 1'b1; tick();
    chk("t5_occ_exit", occupancy, 7);
    chk("t5_not_full", lot_full, 1'b0);
    sensor_exit = 1'b0; tick();

    // Simultaneous edges in IDLE: exit processed, entry dropped
    sensor_entry = 1'b1; sensor_exit = 1'b1; tick();
    chk("both_idle_occ", occupancy, 6);
    chk_leds("both_idle_leds", 4'b0000, 1'b0);
    sensor_entry = 1'b0; sensor_exit = 1'b0; tick();

    // Asynchronous reset mid-operation
    sensor_entry = 1'b1; tick(); sensor_entry = 1'b0;
    chk_leds("mid_wait", 4'b0001, 1'b0);
    rst = 1'b0;
    #1;
    chk_leds("mid_rst_leds", 4'b0000, 1'b0);
    chk("mid_rst_occ", occupancy, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    sensor_entry = 1'b1; tick(); sensor_entry = 1'b0;
    chk_leds("post_rst_wait", 4'b0001, 1'b0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
